// File: rtl/rx_frame_detector.sv
// ----------------------------------------------------------------------------
// rx_frame_detector
//   Receive front-end for the packet-copy path. Finds preamble + SFD in the
//   MII/GMII byte stream, tracks frame state, checks frame length and FCS,
//   and presents the stream one clock late together with a state bus and an
//   error strobe so the downstream writer can discard bad frames.
//
//   Optional feature macro: CRC_CHECK_EN
//     defined   : CRC-32 engine built, FCS mismatch flags the frame bad
//     undefined : no CRC logic, ocrc_err tied low, validity = length + irx_er
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module rx_frame_detector #(
   parameter int pDATA_WIDTH        = 8,
   parameter int pMIN_PACKET_LENGHT = 64,
   parameter int pMAX_PACKET_LENGHT = 1536,
   parameter int pMIN_PREAMBLE      = 1,
   parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1,
   parameter int pFSM_BUS_WIDHT     = 3
) (
   input  logic                      iclk,
   input  logic                      i_rst,
   input  logic                      idv,
   input  logic [pDATA_WIDTH-1:0]    irx_d,
   input  logic                      irx_er,
   output logic                      odv,
   output logic [pDATA_WIDTH-1:0]    orx_d,
   output logic                      orx_er,
   output logic [pFSM_BUS_WIDHT-1:0] oframe_state,
   output logic [pLEN_WIDTH-1:0]     oframe_len,
   output logic                      oframe_done,
   output logic                      ocrc_err,
   output logic                      olen_err
);

   // Frame-state codes shared with the downstream copy logic.
   typedef enum logic [2:0] {
      lpIDLE     = 3'd0,
      lpPREAMBLE = 3'd1,
      lpSFD      = 3'd2,
      lpDATA     = 3'd3,
      lpDONE     = 3'd4,
      lpERROR    = 3'd5,
      lpDISCARD  = 3'd6
   } state_t;

   localparam int lpPRE_W = $clog2(pMIN_PREAMBLE + 1) + 1;

   localparam logic [pDATA_WIDTH-1:0] lpPRE_BYTE = pDATA_WIDTH'(8'h55);
   localparam logic [pDATA_WIDTH-1:0] lpSFD_BYTE = pDATA_WIDTH'(8'hD5);
   localparam logic [lpPRE_W-1:0]     lpPRE_MIN  = lpPRE_W'(pMIN_PREAMBLE);
   localparam logic [pLEN_WIDTH-1:0]  lpLEN_MIN  = pLEN_WIDTH'(pMIN_PACKET_LENGHT);
   localparam logic [pLEN_WIDTH-1:0]  lpLEN_MAX  = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
   localparam logic [pLEN_WIDTH-1:0]  lpLEN_SAT  = pLEN_WIDTH'(pMAX_PACKET_LENGHT + 1);

   state_t                   state_q;
   logic [lpPRE_W-1:0]       pre_cnt_q;
   logic [pLEN_WIDTH-1:0]    len_q;
   logic [pLEN_WIDTH-1:0]    len_d;
   logic                     rx_er_seen_q;   // irx_er observed since SFD
   logic                     win_q;          // 0 = first, 1 = second clk of DONE/ERROR
   logic                     odv_q;
   logic [pDATA_WIDTH-1:0]   orx_d_q;
   logic                     orx_er_q;
   logic                     done_q;
   logic [pLEN_WIDTH-1:0]    frame_len_q;
   logic                     crc_err_q;
   logic                     len_err_q;
   logic                     crc_bad;
   logic                     len_bad;
   logic                     frame_bad;

`ifdef CRC_CHECK_EN
   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // One byte of reflected CRC-32 (poly 0xEDB88320), LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign crc_d   = crc32_byte(crc_q, irx_d[7:0]);
   // Running the FCS through the register leaves the fixed CRC-32 residue.
   assign crc_bad = (crc_q != 32'hDEBB20E3);

   // CRC register: preset between frames, accumulate every valid byte after SFD.
   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         crc_q <= '1;
      end else if ((state_q == lpSFD || state_q == lpDATA) && idv) begin
         crc_q <= crc_d;
      end else if (state_q != lpDATA) begin
         crc_q <= '1;
      end
   end
`else
   assign crc_bad = 1'b0;
`endif

   // Saturating length increment and end-of-frame verdict.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      len_d = len_q;
      if (len_q != lpLEN_SAT) begin
         len_d = len_q + 1'b1;
      end
      len_bad   = (len_q < lpLEN_MIN) || (len_q > lpLEN_MAX);
      frame_bad = crc_bad || len_bad || rx_er_seen_q;
   end

   // Frame FSM with all outputs registered so state/strobes line up with orx_d.
   always_ff @(posedge iclk or posedge i_rst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (i_rst) begin
         state_q      <= lpIDLE;
         pre_cnt_q    <= '0;
         len_q        <= '0;
         rx_er_seen_q <= 1'b0;
         win_q        <= 1'b0;
         odv_q        <= 1'b0;
         orx_d_q      <= '0;
         orx_er_q     <= 1'b0;
         done_q       <= 1'b0;
         frame_len_q  <= '0;
         crc_err_q    <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         odv_q    <= idv;
         orx_d_q  <= irx_d;
         orx_er_q <= 1'b0;
         done_q   <= 1'b0;

         unique case (state_q)
            lpIDLE: begin
               if (idv) begin
                  if (irx_d == lpPRE_BYTE && !irx_er) begin
                     state_q   <= lpPREAMBLE;
                     pre_cnt_q <= lpPRE_W'(1);
                  end else begin
                     state_q <= lpDISCARD;
                  end
               end
            end

            lpPREAMBLE: begin
               if (!idv) begin
                  state_q <= lpIDLE;
               end else if (irx_er) begin
                  state_q <= lpDISCARD;
               end else if (irx_d == lpPRE_BYTE) begin
                  if (pre_cnt_q != '1) begin
                     pre_cnt_q <= pre_cnt_q + 1'b1;
                  end
               end else if (irx_d == lpSFD_BYTE && pre_cnt_q >= lpPRE_MIN) begin
                  state_q      <= lpSFD;
                  len_q        <= '0;
                  rx_er_seen_q <= 1'b0;
               end else begin
                  state_q <= lpDISCARD;
               end
            end

            lpSFD: begin
               if (!idv) begin
                  state_q <= lpIDLE;
               end else if (irx_er) begin
                  state_q <= lpDISCARD;
               end else begin
                  state_q <= lpDATA;
                  len_q   <= len_d;
               end
            end

            lpDATA: begin
               if (idv) begin
                  len_q <= len_d;
                  if (irx_er) begin
                     // Flag the aligned byte at once so the writer can abort early.
                     rx_er_seen_q <= 1'b1;
                     orx_er_q     <= 1'b1;
                  end
               end else begin
                  state_q     <= frame_bad ? lpERROR : lpDONE;
                  orx_er_q    <= frame_bad;
                  done_q      <= 1'b1;
                  frame_len_q <= len_q;
                  crc_err_q   <= crc_bad;
                  len_err_q   <= len_bad;
                  win_q       <= 1'b0;
               end
            end

            lpDONE, lpERROR: begin
               if (!win_q) begin
                  win_q    <= 1'b1;
                  orx_er_q <= (state_q == lpERROR);
               end else begin
                  // Bytes arriving inside the window broke the IFG: drop them.
                  state_q <= idv ? lpDISCARD : lpIDLE;
               end
            end

            lpDISCARD: begin
               if (!idv) begin
                  state_q <= lpIDLE;
               end
            end

            default: begin
               state_q <= lpIDLE;
            end
         endcase
      end
   end

   assign odv          = odv_q;
   assign orx_d        = orx_d_q;
   assign orx_er       = orx_er_q;
   assign oframe_state = pFSM_BUS_WIDHT'(state_q);
   assign oframe_len   = frame_len_q;
   assign oframe_done  = done_q;
   assign ocrc_err     = crc_err_q;
   assign olen_err     = len_err_q;

endmodule

// File: tb/tb_rx_frame_detector.sv
// ----------------------------------------------------------------------------
// tb_rx_frame_detector
//   Directed bench for rx_frame_detector: good/bad FCS, runt/giant, length
//   boundaries, irx_er in DATA, broken preamble and asynchronous reset.
//   Expectations follow CRC_CHECK_EN when the bench is built with it.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rx_frame_detector;

`ifdef CRC_CHECK_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif
   localparam int IFG = 12;

   logic        clk;
   logic        i_rst;
   logic        idv;
   logic [7:0]  irx_d;
   logic        irx_er;
   logic        odv;
   logic [7:0]  orx_d;
   logic        orx_er;
   logic [2:0]  oframe_state;
   logic [11:0] oframe_len;
   logic        oframe_done;
   logic        ocrc_err;
   logic        olen_err;

   rx_frame_detector dut (
      .iclk        (clk),
      .i_rst       (i_rst),
      .idv         (idv),
      .irx_d       (irx_d),
      .irx_er      (irx_er),
      .odv         (odv),
      .orx_d       (orx_d),
      .orx_er      (orx_er),
      .oframe_state(oframe_state),
      .oframe_len  (oframe_len),
      .oframe_done (oframe_done),
      .ocrc_err    (ocrc_err),
      .olen_err    (olen_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor totals (written only by the monitor) and snapshots (initial block only).
   int         tot_sfd = 0, tot_done_st = 0, tot_err_st = 0, tot_disc = 0;
   int         tot_pulse = 0, tot_er_data = 0, tot_er_win = 0;
   int         data_idx = 0, er_idx = -1;
   logic [7:0] sfd_byte = 8'h00;
   int         s_sfd, s_done_st, s_err_st, s_disc, s_pulse, s_er_data, s_er_win;

   logic [7:0] frm[$];
   int         data_start;

   // Sample on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      case (oframe_state)
         3'd2: begin
            tot_sfd  <= tot_sfd + 1;
            sfd_byte <= orx_d;
            data_idx <= 0;
         end
         3'd3: begin
            if (odv) begin
               if (orx_er) begin
                  tot_er_data <= tot_er_data + 1;
                  er_idx      <= data_idx;
               end
               data_idx <= data_idx + 1;
            end
         end
         3'd4: begin
            tot_done_st <= tot_done_st + 1;
            if (orx_er) tot_er_win <= tot_er_win + 1;
         end
         3'd5: begin
            tot_err_st <= tot_err_st + 1;
            if (orx_er) tot_er_win <= tot_er_win + 1;
         end
         3'd6: tot_disc <= tot_disc + 1;
         default: ;
      endcase
      if (oframe_done) tot_pulse <= tot_pulse + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // n_len counts bytes after SFD including the 4 FCS bytes.
   task automatic build_frame(input int n_pre, input int n_len, input bit corrupt);
      logic [31:0] c;
      logic [7:0]  b;
      frm.delete();
      for (int i = 0; i < n_pre; i++) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      data_start = n_pre + 1;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n_len - 4; i++) begin
         b = 8'(i * 37 + 11);
         frm.push_back(b);
         c = crc_step(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) begin
         b = c[8*k +: 8];
         if (corrupt && k == 3) b = ~b;
         frm.push_back(b);
      end
   endtask

   task automatic drive(input logic dv, input logic [7:0] d, input logic er);
      @(posedge clk);
      #1;
      idv    = dv;
      irx_d  = d;
      irx_er = er;
   endtask

   task automatic send_frame(input int er_at);
      for (int i = 0; i < frm.size(); i++)
         drive(1'b1, frm[i], (er_at >= 0) && ((i - data_start) == er_at));
      repeat (IFG) drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic snap();
      s_sfd = tot_sfd; s_done_st = tot_done_st; s_err_st = tot_err_st; s_disc = tot_disc;
      s_pulse = tot_pulse; s_er_data = tot_er_data; s_er_win = tot_er_win;
   endtask

   task automatic check_frame(input string tag, input int e_done, input int e_err,
                              input int e_len, input bit e_len_err, input bit e_crc_err);
      check({tag, " sfd_cycles"}, tot_sfd - s_sfd, 1);
      check({tag, " sfd_byte"}, {24'h0, sfd_byte}, 32'hD5);
      check({tag, " done_cycles"}, tot_done_st - s_done_st, e_done);
      check({tag, " error_cycles"}, tot_err_st - s_err_st, e_err);
      check({tag, " window_rx_er"}, tot_er_win - s_er_win, e_err);
      check({tag, " done_pulses"}, tot_pulse - s_pulse, 1);
      check({tag, " frame_len"}, {20'h0, oframe_len}, e_len);
      check({tag, " len_err"}, {31'h0, olen_err}, {31'h0, e_len_err});
      check({tag, " crc_err"}, {31'h0, ocrc_err}, {31'h0, e_crc_err});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " state"}, {29'h0, oframe_state}, 0);
      check({tag, " odv"}, {31'h0, odv}, 0);
      check({tag, " orx_d"}, {24'h0, orx_d}, 0);
      check({tag, " orx_er"}, {31'h0, orx_er}, 0);
      check({tag, " done"}, {31'h0, oframe_done}, 0);
      check({tag, " len"}, {20'h0, oframe_len}, 0);
      check({tag, " crc_err"}, {31'h0, ocrc_err}, 0);
      check({tag, " len_err"}, {31'h0, olen_err}, 0);
   endtask

   initial begin
      // Inputs active during reset must not leak to the outputs.
      i_rst  = 1'b1;
      idv    = 1'b1;
      irx_d  = 8'h55;
      irx_er = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      idv = 1'b0;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      repeat (3) drive(1'b0, 8'h00, 1'b0);

      // 1: minimum-length good frame.
      snap(); build_frame(7, 64, 1'b0); send_frame(-1);
      check_frame("t1_good64", 2, 0, 64, 1'b0, 1'b0);
      check("t1 rx_er_data", tot_er_data - s_er_data, 0);

      // 2: last FCS byte flipped.
      snap(); build_frame(7, 64, 1'b1); send_frame(-1);
      check_frame("t2_badfcs", CRC_ON ? 0 : 2, CRC_ON ? 2 : 0, 64, 1'b0, CRC_ON);

      // 3: runt, one-short, maximum and giant frames.
      snap(); build_frame(7, 40, 1'b0); send_frame(-1);
      check_frame("t3_runt40", 0, 2, 40, 1'b1, 1'b0);
      snap(); build_frame(7, 63, 1'b0); send_frame(-1);
      check_frame("t3_runt63", 0, 2, 63, 1'b1, 1'b0);
      snap(); build_frame(7, 1536, 1'b0); send_frame(-1);
      check_frame("t3_max1536", 2, 0, 1536, 1'b0, 1'b0);
      snap(); build_frame(7, 1600, 1'b0); send_frame(-1);
      check_frame("t3_giant", 0, 2, 1537, 1'b1, 1'b0);

      // 4: irx_er on data byte 20 of a 100-byte frame.
      snap(); build_frame(7, 100, 1'b0); send_frame(20);
      check_frame("t4_rxer", 0, 2, 100, 1'b0, 1'b0);
      check("t4 rx_er_data_cycles", tot_er_data - s_er_data, 1);
      check("t4 rx_er_index", er_idx, 20);

      // 5: broken preamble, then a normal frame (single 0x55 preamble).
      snap();
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hA5, 1'b0);
      repeat (10) drive(1'b1, 8'hD5, 1'b0);
      repeat (IFG) drive(1'b0, 8'h00, 1'b0);
      check("t5 discard_cycles", tot_disc - s_disc, 11);
      check("t5 sfd_cycles", tot_sfd - s_sfd, 0);
      check("t5 done_pulses", tot_pulse - s_pulse, 0);
      snap(); build_frame(1, 72, 1'b0); send_frame(-1);
      check_frame("t5_after", 2, 0, 72, 1'b0, 1'b0);

      // 6: asynchronous reset in the middle of DATA.
      build_frame(7, 64, 1'b0);
      for (int i = 0; i < 30; i++) drive(1'b1, frm[i], 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      check_reset_outputs("t6_async_rst");
      idv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      snap(); build_frame(7, 80, 1'b0); send_frame(-1);
      check_frame("t6_after", 2, 0, 80, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
